y86_decode_regfile: RTL and testbench

- Parametrised successor to the combinational decode/register-read stage: owns the register file itself instead of taking registers as ports.
- Selects srcA/srcB from icode, rA and rB, and reads them.
- Accepts two writeback ports (E and M) and registers its results into a one-entry valid/ready output stage.
- Sits between fetch and execute in the Y86-64 processor.

---
 rtl/y86_pkg.sv | 25 ++
 rtl/y86_src_select.sv | 53 +++++
 rtl/y86_decode_regfile.sv | 126 ++++++++++++
 tb/tb_y86_decode_regfile.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 decode definitions: instruction codes, the RNONE register
// marker and a register-index range helper.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    // RNONE (4'hF) is never below a register count of at most 15.
    function automatic logic idx_in_range(input logic [3:0] idx, input int unsigned nregs);
        return (32'(idx) < nregs);
    endfunction

endpackage

// File: rtl/y86_src_select.sv
// Combinational source-register selection for the decode stage: maps
// (icode, rA, rB) to the srcA/srcB register indices.
module y86_src_select
    import y86_pkg::*;
#(
    parameter int RSP_IDX = 4
) (
    input  logic [3:0] icode,
    input  logic [3:0] ra,
    input  logic [3:0] rb,
    output logic [3:0] src_a,
    output logic [3:0] src_b
);

    localparam logic [3:0] RSP_SEL = 4'(RSP_IDX);

    // Source selection per instruction class.
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        case (icode)
            I_OPQ, I_RMMOV: begin
                src_a = ra;
                src_b = rb;
            end
            I_CMOV: begin
                src_a = ra;
                src_b = RNONE;
            end
            I_MRMOV: begin
                src_a = RNONE;
                src_b = rb;
            end
            I_PUSH: begin
                src_a = ra;
                src_b = RSP_SEL;
            end
            I_POP, I_RET: begin
                src_a = RSP_SEL;
                src_b = RSP_SEL;
            end
            I_CALL: begin
                src_a = RNONE;
                src_b = RSP_SEL;
            end
            default: begin
                src_a = RNONE;
                src_b = RNONE;
            end
        endcase
    end

endmodule

// File: rtl/y86_decode_regfile.sv
// Y86-64 decode stage with its own register file, two writeback ports (M wins
// over E) and a one-entry valid/ready output register.
// Optional macro Y86_DECODE_WB_BYPASS_EN: same-cycle writeback bypass into reads.
module y86_decode_regfile
    import y86_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                NREGS    = 15,
    parameter int                RSP_IDX  = 4,
    parameter logic [DATA_W-1:0] RSP_INIT = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_rA,
    input  logic [3:0]        in_rB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic [3:0]        out_srcA,
    output logic [3:0]        out_srcB,
    output logic [DATA_W-1:0] out_valA,
    output logic [DATA_W-1:0] out_valB,
    input  logic              wE_en,
    input  logic [3:0]        wE_dst,
    input  logic [DATA_W-1:0] wE_data,
    input  logic              wM_en,
    input  logic [3:0]        wM_dst,
    input  logic [DATA_W-1:0] wM_data
);

    logic [DATA_W-1:0] regs_r [NREGS];

    logic [3:0]        src_a_s;
    logic [3:0]        src_b_s;
    logic [DATA_W-1:0] val_a_s;
    logic [DATA_W-1:0] val_b_s;
    logic              accept_s;

    logic              out_valid_r;
    logic [3:0]        out_icode_r;
    logic [3:0]        out_src_a_r;
    logic [3:0]        out_src_b_r;
    logic [DATA_W-1:0] out_val_a_r;
    logic [DATA_W-1:0] out_val_b_r;

    y86_src_select #(.RSP_IDX(RSP_IDX)) u_src_select (
        .icode (in_icode),
        .ra    (in_rA),
        .rb    (in_rB),
        .src_a (src_a_s),
        .src_b (src_b_s)
    );

    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Register read; out-of-range sources (including RNONE) fall through to 0.
    always_comb begin
        val_a_s = {DATA_W{1'b0}};
        val_b_s = {DATA_W{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            val_a_s = (src_a_s == 4'(i)) ? regs_r[i] : val_a_s;
            val_b_s = (src_b_s == 4'(i)) ? regs_r[i] : val_b_s;
        end
`ifdef Y86_DECODE_WB_BYPASS_EN
        // E applied first so a matching M write overrides it.
        val_a_s = (idx_in_range(src_a_s, NREGS) && wE_en && (wE_dst == src_a_s)) ? wE_data : val_a_s;
        val_b_s = (idx_in_range(src_b_s, NREGS) && wE_en && (wE_dst == src_b_s)) ? wE_data : val_b_s;
        val_a_s = (idx_in_range(src_a_s, NREGS) && wM_en && (wM_dst == src_a_s)) ? wM_data : val_a_s;
        val_b_s = (idx_in_range(src_b_s, NREGS) && wM_en && (wM_dst == src_b_s)) ? wM_data : val_b_s;
`endif
    end

    // Register file writeback; M port has priority on a shared destination.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= (i == RSP_IDX) ? RSP_INIT : {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wM_en && (wM_dst == 4'(i))) begin
                    regs_r[i] <= wM_data;
                end else if (wE_en && (wE_dst == 4'(i))) begin
                    regs_r[i] <= wE_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // One-entry output stage; captured values stay frozen while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_icode_r <= 4'h0;
            out_src_a_r <= RNONE;
            out_src_b_r <= RNONE;
            out_val_a_r <= {DATA_W{1'b0}};
            out_val_b_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_icode_r <= in_icode;
            out_src_a_r <= src_a_s;
            out_src_b_r <= src_b_s;
            out_val_a_r <= val_a_s;
            out_val_b_r <= val_b_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_icode = out_icode_r;
    assign out_srcA  = out_src_a_r;
    assign out_srcB  = out_src_b_r;
    assign out_valA  = out_val_a_r;
    assign out_valB  = out_val_b_r;

endmodule

// File: tb/tb_y86_decode_regfile.sv
// Self-checking bench for y86_decode_regfile: directed vector table, hand-written
// stall/bypass/reset sequences and random stimulus against a behavioural model.
module tb_y86_decode_regfile;

    localparam int          DW   = 64;
    localparam int          NR   = 15;
    localparam int          RSP  = 4;
    localparam logic [63:0] RSPI = 64'h100;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]    in_icode, in_rA, in_rB, out_icode, out_srcA, out_srcB;
    logic [DW-1:0] out_valA, out_valB, wE_data, wM_data;
    logic          wE_en, wM_en;
    logic [3:0]    wE_dst, wM_dst;

    always #5 clk = ~clk;

    y86_decode_regfile #(.DATA_W(DW), .NREGS(NR), .RSP_IDX(RSP), .RSP_INIT(RSPI)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB),
        .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
        .out_srcA(out_srcA), .out_srcB(out_srcB), .out_valA(out_valA), .out_valB(out_valB),
        .wE_en(wE_en), .wE_dst(wE_dst), .wE_data(wE_data),
        .wM_en(wM_en), .wM_dst(wM_dst), .wM_data(wM_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference state
    logic [63:0] mregs [NR];
    logic        m_known = 1'b0;
    logic        m_valid;
    logic [3:0]  m_icode, m_srcA, m_srcB;
    logic [63:0] m_valA, m_valB;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void msel(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                                 output logic [3:0] a, output logic [3:0] b);
        a = 4'hF;
        b = 4'hF;
        case (ic)
            4'h6, 4'h4: begin a = ra;   b = rb;   end
            4'h2:       begin a = ra;             end
            4'h5:       begin                b = rb;   end
            4'hA:       begin a = ra;   b = 4'd4; end
            4'hB, 4'h9: begin a = 4'd4; b = 4'd4; end
            4'h8:       begin                b = 4'd4; end
            default:    begin end
        endcase
    endfunction

    function automatic logic [63:0] mread(input logic [3:0] src);
        if (int'(src) >= NR) return 64'h0;
`ifdef Y86_DECODE_WB_BYPASS_EN
        if (wM_en && wM_dst == src) return wM_data;
        if (wE_en && wE_dst == src) return wE_data;
`endif
        return mregs[src];
    endfunction

    // One clock: check in_ready, advance the model, then compare after the edge.
    task automatic tick();
        logic acc;
        #1;
        if (m_known) chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
        if (!rst_n) begin
            m_known = 1'b1;
            m_valid = 1'b0; m_icode = 4'h0; m_srcA = 4'hF; m_srcB = 4'hF;
            m_valA = 64'h0; m_valB = 64'h0;
            for (int i = 0; i < NR; i++) mregs[i] = (i == RSP) ? RSPI : 64'h0;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            if (acc) begin
                msel(in_icode, in_rA, in_rB, m_srcA, m_srcB);
                m_valA  = mread(m_srcA);
                m_valB  = mread(m_srcB);
                m_icode = in_icode;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (wE_en && int'(wE_dst) < NR) mregs[wE_dst] = wE_data;
            if (wM_en && int'(wM_dst) < NR) mregs[wM_dst] = wM_data;
        end
        @(posedge clk);
        #1;
        if (m_known) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
            if (m_valid) begin
                chk("out_icode", {60'd0, out_icode}, {60'd0, m_icode});
                chk("out_srcA", {60'd0, out_srcA}, {60'd0, m_srcA});
                chk("out_srcB", {60'd0, out_srcB}, {60'd0, m_srcB});
                chk("out_valA", out_valA, m_valA);
                chk("out_valB", out_valB, m_valB);
            end
        end
    endtask

    task automatic idle();
        rst_n = 1'b1; in_valid = 1'b0; in_icode = 4'h1; in_rA = 4'hF; in_rB = 4'hF;
        out_ready = 1'b1;
        wE_en = 1'b0; wE_dst = 4'h0; wE_data = 64'h0;
        wM_en = 1'b0; wM_dst = 4'h0; wM_data = 64'h0;
    endtask

    task automatic issue(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        in_valid = 1'b1; in_icode = ic; in_rA = ra; in_rB = rb;
    endtask

    typedef struct {
        logic [3:0]  icode, ra, rb;
        logic [3:0]  srcA, srcB;
        logic [63:0] valA, valB;
    } vec_t;

    vec_t vt [14];
    logic [63:0] bypass_exp;

    initial begin
        // Register state at table time: r1=11 r2=7 r3=9 r4=100, others 0
        vt[0]  = '{4'h6, 4'h4, 4'h0, 4'h4, 4'h0, 64'h100, 64'h0};
        vt[1]  = '{4'h6, 4'h3, 4'h1, 4'h3, 4'h1, 64'h9,   64'h11};
        vt[2]  = '{4'hA, 4'h2, 4'hF, 4'h2, 4'h4, 64'h7,   64'h100};
        vt[3]  = '{4'h5, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};
        vt[4]  = '{4'hB, 4'h0, 4'h0, 4'h4, 4'h4, 64'h100, 64'h100};
        vt[5]  = '{4'h8, 4'hF, 4'hF, 4'hF, 4'h4, 64'h0,   64'h100};
        vt[6]  = '{4'h9, 4'hF, 4'hF, 4'h4, 4'h4, 64'h100, 64'h100};
        vt[7]  = '{4'h2, 4'h2, 4'h3, 4'h2, 4'hF, 64'h7,   64'h0};
        vt[8]  = '{4'h4, 4'h1, 4'h2, 4'h1, 4'h2, 64'h11,  64'h7};
        vt[9]  = '{4'h3, 4'h3, 4'h4, 4'hF, 4'hF, 64'h0,   64'h0};
        vt[10] = '{4'h7, 4'h1, 4'h2, 4'hF, 4'hF, 64'h0,   64'h0};
        vt[11] = '{4'h6, 4'hE, 4'h3, 4'hE, 4'h3, 64'h0,   64'h9};
        vt[12] = '{4'h0, 4'h1, 4'h2, 4'hF, 4'hF, 64'h0,   64'h0};
        vt[13] = '{4'hC, 4'h1, 4'h2, 4'hF, 4'hF, 64'h0,   64'h0};

        idle();
        rst_n = 1'b0;
        tick();
        chk("rst out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst out_icode", {60'd0, out_icode}, 64'd0);
        chk("rst out_srcA", {60'd0, out_srcA}, 64'hF);
        chk("rst out_srcB", {60'd0, out_srcB}, 64'hF);
        chk("rst out_valA", out_valA, 64'd0);
        chk("rst out_valB", out_valB, 64'd0);
        chk("rst in_ready", {63'd0, in_ready}, 64'd1);

        // Register setup, including same-cycle E/M collision on r3
        idle();
        wE_en = 1'b1; wE_dst = 4'd2; wE_data = 64'h7;
        wM_en = 1'b1; wM_dst = 4'd1; wM_data = 64'h11;
        tick();
        wE_dst = 4'd3; wE_data = 64'h5;
        wM_dst = 4'd3; wM_data = 64'h9;
        tick();

        for (int i = 0; i < 14; i++) begin
            idle();
            issue(vt[i].icode, vt[i].ra, vt[i].rb);
            tick();
            chk($sformatf("tbl%0d valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("tbl%0d srcA", i), {60'd0, out_srcA}, {60'd0, vt[i].srcA});
            chk($sformatf("tbl%0d srcB", i), {60'd0, out_srcB}, {60'd0, vt[i].srcB});
            chk($sformatf("tbl%0d valA", i), out_valA, vt[i].valA);
            chk($sformatf("tbl%0d valB", i), out_valB, vt[i].valB);
        end

        // Stall: held outputs survive writes to their source register
        idle();
        issue(4'h6, 4'h2, 4'h1);
        tick();
        issue(4'h6, 4'h1, 4'h2);
        out_ready = 1'b0;
        wE_en = 1'b1; wE_dst = 4'd2; wE_data = 64'h77;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall valA", out_valA, 64'h7);
            chk("stall valB", out_valB, 64'h11);
            chk("stall srcA", {60'd0, out_srcA}, 64'd2);
        end
        out_ready = 1'b1;
        wE_en = 1'b0;
        tick();
        chk("release srcA", {60'd0, out_srcA}, 64'd1);
        chk("release valA", out_valA, 64'h11);
        chk("release valB", out_valB, 64'h77);

        // Same-cycle write versus read
        idle();
        issue(4'h6, 4'h1, 4'h0);
        wE_en = 1'b1; wE_dst = 4'd1; wE_data = 64'hAA;
`ifdef Y86_DECODE_WB_BYPASS_EN
        bypass_exp = 64'hAA;
`else
        bypass_exp = 64'h11;
`endif
        tick();
        chk("wb_same_cycle valA", out_valA, bypass_exp);
        idle();
        issue(4'h6, 4'h1, 4'h0);
        tick();
        chk("wb_next_cycle valA", out_valA, 64'hAA);

        // Reset with a held result and pending writes
        idle();
        issue(4'h6, 4'h5, 4'h4);
        out_ready = 1'b0;
        rst_n = 1'b0;
        wE_en = 1'b1; wE_dst = 4'd5; wE_data = 64'h55;
        wM_en = 1'b1; wM_dst = 4'd4; wM_data = 64'h66;
        tick();
        chk("rst2 out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst2 in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst2 srcA", {60'd0, out_srcA}, 64'hF);
        idle();
        issue(4'h6, 4'h5, 4'h4);
        tick();
        chk("rst2 r5", out_valA, 64'h0);
        chk("rst2 rsp", out_valB, 64'h100);
        idle();
        issue(4'h6, 4'h1, 4'h2);
        tick();
        chk("rst2 r1", out_valA, 64'h0);
        chk("rst2 r2", out_valB, 64'h0);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = $urandom_range(0, 1);
            in_icode  = 4'($urandom);
            in_rA     = 4'($urandom);
            in_rB     = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            wE_en     = $urandom_range(0, 1);
            wE_dst    = 4'($urandom);
            wE_data   = {$urandom, $urandom};
            wM_en     = $urandom_range(0, 1);
            wM_dst    = ($urandom_range(0, 3) == 0) ? wE_dst : 4'($urandom);
            wM_data   = {$urandom, $urandom};
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
